// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if
// Bundles the enable/serial/parallel signals of the SPI ADC reader.
//   master : the reader itself (drives SPI clock/select and the sample stream)
//   slave  : the environment (drives enable and the ADC serial data)
// Signals:
//   i_enable      level request to start frames
//   i_miso        serial data from the ADC
//   o_sclk        SPI clock, CPOL=0
//   o_cs_n        ADC chip select, active low
//   o_data        last captured sample
//   o_data_valid  one-cycle strobe when o_data updates
//   o_busy        high whenever a frame is in progress
interface adc_spi_reader_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  i_enable;
  logic                  i_miso;
  logic                  o_sclk;
  logic                  o_cs_n;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_busy;

  modport master (
    input  i_enable,
    input  i_miso,
    output o_sclk,
    output o_cs_n,
    output o_data,
    output o_data_valid,
    output o_busy
  );

  modport slave (
    output i_enable,
    output i_miso,
    input  o_sclk,
    input  o_cs_n,
    input  o_data,
    input  o_data_valid,
    input  o_busy
  );
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader
// Reads one conversion word per frame from a serial SPI ADC (MSB first) and
// presents it as a parallel word with a single-cycle valid strobe. Frames run
// back-to-back while i_enable is high.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   bus (master)     enable/miso in; sclk, cs_n, data, data_valid, busy out
//   o_sample_count   16-bit count of completed frames (only when the macro
//                    ADC_SPI_READER_SAMPLE_COUNT_EN is defined)
//
// Optional feature macro: ADC_SPI_READER_SAMPLE_COUNT_EN
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | cs_n high, sclk low; waits for i_enable
// S_SETUP | cs_n low for CS_SETUP cycles before the first sclk edge
// S_SHIFT | sclk toggles every CLK_DIV cycles; miso shifted on rise
// S_DONE  | one cycle, cs_n high, o_data loaded, o_data_valid high
module adc_spi_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
  output logic [15:0]        o_sample_count,
`endif
  adc_spi_reader_if.master   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SET_W = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(CS_SETUP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [SET_W-1:0]      r_setup_cnt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_data_valid;
  logic                  r_busy;
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
  logic [15:0]           r_sample_count;
`endif

  // Outputs are registered with the value of the state being entered, so
  // every output is valid for exactly the cycles spent in that state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_setup_cnt    <= '0;
      r_div_cnt      <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_data         <= '0;
      r_sclk         <= 1'b0;
      r_cs_n         <= 1'b1;
      r_data_valid   <= 1'b0;
      r_busy         <= 1'b0;
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
      r_sample_count <= '0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_enable) begin
            r_state     <= S_SETUP;
            r_cs_n      <= 1'b0;
            r_busy      <= 1'b1;
            r_setup_cnt <= SET_LOAD;
          end
        end

        S_SETUP: begin
          // Down-counter: SET_LOAD..0 gives exactly CS_SETUP cycles.
          if (r_setup_cnt == '0) begin
            r_state   <= S_SHIFT;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
          end else begin
            r_setup_cnt <= r_setup_cnt - SET_W'(1);
          end
        end

        S_SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!r_sclk) begin
              // Rising edge: capture miso in the same cycle sclk goes high.
              r_sclk    <= 1'b1;
              r_shift   <= (r_shift << 1) | DATA_WIDTH'(bus.i_miso);
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end else begin
              r_sclk <= 1'b0;
              // Falling edge after the last rising edge closes the frame.
              if (r_bit_cnt == BIT_LAST) begin
                r_state      <= S_DONE;
                r_cs_n       <= 1'b1;
                r_data       <= r_shift;
                r_data_valid <= 1'b1;
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
                r_sample_count <= r_sample_count + 16'd1;
`endif
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sclk       = r_sclk;
  assign bus.o_cs_n       = r_cs_n;
  assign bus.o_data       = r_data;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_busy       = r_busy;
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
  assign o_sample_count   = r_sample_count;
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
`timescale 1ns/1ps
module tb_adc_spi_reader;
  localparam int DW     = 12;
  localparam int CD     = 2;
  localparam int CSS    = 2;
  localparam int LAT    = CSS + 2*CD*DW + 1;  // enable-sample cycle to valid
  localparam int PERIOD = LAT + 1;            // back-to-back frame period

  typedef struct {
    logic [DW-1:0] word;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_spi_reader_if #(.DATA_WIDTH(DW)) bus ();
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
  logic [15:0] sample_count;
`endif

  adc_spi_reader #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CD),
    .CS_SETUP  (CSS)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
    .o_sample_count (sample_count),
`endif
    .bus            (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_valid  = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] adc_q[$];
  int            gap_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- ADC model + monitor/scoreboard ----------------
  logic          prev_sclk = 1'b0, prev_cs = 1'b1, prev_valid = 1'b0;
  logic [DW-1:0] adc_word = '0;
  int            bit_idx = 0;
  int            hi_len = 0, lo_len = 0;
  bit            seen_fall = 0;
  int            cs_low_len = 0, cs_hi_len = 0, rise_cnt = 0, edge_cnt = 0;
  int            last_cs_low = 0, last_rise = 0;
  exp_t          e;

  always @(negedge clk) begin
    // frame start
    if (prev_cs && !bus.o_cs_n) begin
      adc_word   = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
      bit_idx    = 0;
      gap_q.push_back(cs_hi_len);
      cs_low_len = 0;
      cs_hi_len  = 0;
      rise_cnt   = 0;
      edge_cnt   = 0;
      seen_fall  = 0;
    end
    if (!prev_cs && bus.o_cs_n) begin
      last_cs_low = cs_low_len;
      last_rise   = rise_cnt;
    end
    if (bus.o_cs_n) cs_hi_len++; else cs_low_len++;

    if (bus.o_sclk && !prev_sclk) begin
      rise_cnt++;
      edge_cnt++;
      bit_idx++;
      if (seen_fall) check("sclk_low_phase", lo_len, CD);
      hi_len = 0;
    end
    if (!bus.o_sclk && prev_sclk) begin
      edge_cnt++;
      check("sclk_high_phase", hi_len, CD);
      seen_fall = 1;
      lo_len    = 0;
    end
    if (bus.o_sclk) hi_len++; else lo_len++;

    if (bus.o_cs_n) check("sclk_low_while_cs_high", bus.o_sclk, 1'b0);

    // ADC presents the next bit well before the sampling rising edge
    bus.i_miso = (bit_idx < DW) ? adc_word[DW-1-bit_idx] : 1'b0;

    if (bus.o_data_valid) begin
      n_valid++;
      check("valid_not_consecutive", prev_valid, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual data=0x%0h required=no_valid (t=%0t)", bus.o_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("data", bus.o_data, e.word);
        check("valid_cycle", cyc, e.cyc);
      end
    end

    prev_sclk  = bus.o_sclk;
    prev_cs    = bus.o_cs_n;
    prev_valid = bus.o_data_valid;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [DW-1:0] w, input int offs);
    adc_q.push_back(w);
    exp_q.push_back('{word: w, cyc: cyc + offs});
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int k = 0;
    while (n_valid < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({"timeout_", name}, (n_valid >= target), 1'b1);
  endtask

  task automatic pulse_enable();
    bus.i_enable = 1'b1;
    @(negedge clk);
    bus.i_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int k;
    bus.i_enable = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n",  bus.o_cs_n, 1'b1);
    check("rst_sclk",  bus.o_sclk, 1'b0);
    check("rst_data",  bus.o_data, 12'h000);
    check("rst_valid", bus.o_data_valid, 1'b0);
    check("rst_busy",  bus.o_busy, 1'b0);
`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
    check("rst_sample_count", sample_count, 16'h0000);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single frame
    issue(12'hA5C, LAT);
    pulse_enable();
    check("busy_in_frame", bus.o_busy, 1'b1);
    wait_valid(1, 200, "single");
    @(negedge clk);
    check("single_cs_low_len", last_cs_low, 50);
    check("single_rise_cnt", last_rise, 12);
    repeat (60) @(negedge clk);
    check("single_no_more_frames", n_valid, 1);
    check("single_idle_busy", bus.o_busy, 1'b0);

    // continuous
    nv = n_valid;
    gap_q.delete();
    issue(12'h001, LAT);
    issue(12'hFFF, LAT + PERIOD);
    issue(12'h800, LAT + 2*PERIOD);
    bus.i_enable = 1'b1;
    wait_valid(nv + 2, 300, "cont2");
    repeat (8) @(negedge clk);
    bus.i_enable = 1'b0;
    wait_valid(nv + 3, 200, "cont3");
    repeat (60) @(negedge clk);
    check("cont_frame_count", n_valid, nv + 3);
    check("cont_frames_started", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("cont_cs_gap1", gap_q[1], 2);
      check("cont_cs_gap2", gap_q[2], 2);
    end

    // enable drop in SHIFT cycle 10
    nv = n_valid;
    issue(12'h5A3, LAT);
    bus.i_enable = 1'b1;
    repeat (12) @(negedge clk);
    bus.i_enable = 1'b0;
    check("drop_busy_mid", bus.o_busy, 1'b1);
    wait_valid(nv + 1, 200, "drop");
    @(negedge clk);
    check("drop_idle_busy", bus.o_busy, 1'b0);
    check("drop_idle_cs_n", bus.o_cs_n, 1'b1);
    repeat (60) @(negedge clk);
    check("drop_single_valid", n_valid, nv + 1);

    // reset mid-SHIFT
    nv = n_valid;
    issue(12'h123, LAT);
    pulse_enable();
    wait_valid(nv + 1, 200, "pre_reset");
    repeat (3) @(negedge clk);
    adc_q.push_back(12'h7E1);   // aborted frame: no valid expected
    pulse_enable();
    repeat (2) @(negedge clk);
    k = 0;
    while (edge_cnt < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_six_edges", (edge_cnt >= 6), 1'b1);
    check("data_held_before_reset", bus.o_data, 12'h123);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n",  bus.o_cs_n, 1'b1);
    check("abort_sclk",  bus.o_sclk, 1'b0);
    check("abort_data",  bus.o_data, 12'h000);
    check("abort_valid", bus.o_data_valid, 1'b0);
    check("abort_busy",  bus.o_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_valid", n_valid, nv + 1);
    issue(12'h3C6, LAT);
    pulse_enable();
    wait_valid(nv + 2, 200, "post_reset");
    repeat (3) @(negedge clk);

`ifdef ADC_SPI_READER_SAMPLE_COUNT_EN
    force dut.r_sample_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_sample_count;
    nv = n_valid;
    issue(12'h0F0, LAT);
    pulse_enable();
    wait_valid(nv + 1, 200, "count1");
    check("sample_count_ffff", sample_count, 16'hFFFF);
    repeat (3) @(negedge clk);
    issue(12'h90F, LAT);
    pulse_enable();
    wait_valid(nv + 2, 200, "count2");
    check("sample_count_wrap", sample_count, 16'h0000);
    repeat (3) @(negedge clk);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

- Front-end sampler that reads a serial SPI ADC.
- Generates chip-select and serial clock, shifts in one conversion result MSB-first, and presents it as a parallel word with a single-cycle valid strobe.
- It is the producer of the ADC data-valid stream that feeds the decimating sample trigger and the IAGC datapath.
- Frames run back-to-back while enabled; each valid pulse marks one fresh sample.

## Interface
Parameters:
- DATA_WIDTH, 12, bits per ADC conversion word (>= 1).
- CLK_DIV, 2, system clocks per SCLK half-period (>= 1).
- CS_SETUP, 2, cycles `o_cs_n` is held low before the first SCLK edge (>= 1).

Ports:
- i_clock  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  1  level; sampled only in IDLE to start a frame.
- i_miso  input  1  serial data from ADC.
- o_sclk  output  1  SPI clock, CPOL=0 (idles low).
- o_cs_n  output  1  ADC chip select, active low.
- o_data  output  DATA_WIDTH  last captured sample; held until next DONE.
- o_data_valid  output  1  one-cycle pulse when `o_data` updates.
- o_busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, SHIFT, DONE. All outputs are registered.
- IDLE:
  - `o_cs_n`=1, `o_sclk`=0.
  - If `i_enable`=1, go to SETUP and load the setup counter.
- SETUP:
  - `o_cs_n`=0, `o_sclk`=0, for exactly CS_SETUP cycles.
  - Then go to SHIFT with the divider counter and bit counter cleared.
- SHIFT:
  - `o_cs_n`=0.
  - Divider counter counts 0..CLK_DIV-1; `o_sclk` toggles when the divider wraps.
  - On every low->high transition of `o_sclk`, `i_miso` is shifted into the LSB of the shift register, so the first bit received ends as the MSB.
  - After the DATA_WIDTH-th rising edge and its following falling edge, go to DONE.
  - SHIFT lasts exactly 2*CLK_DIV*DATA_WIDTH cycles.
- DONE:
  - One cycle, `o_cs_n`=1, `o_sclk`=0.
  - `o_data` loads the shift register and `o_data_valid`=1.
  - Unconditionally returns to IDLE.
- Deassertion of `i_enable` outside IDLE has no effect; the frame in progress completes.
- Counter widths are sized by $clog2 of their maximum value. No arithmetic overflow is possible.

## Timing
- Reset values: `o_cs_n`=1, `o_sclk`=0, `o_data`=0, `o_data_valid`=0, `o_busy`=0, state=IDLE, shift register=0.
- Reset asserted mid-frame forces these values immediately (asynchronously). No `o_data_valid` is issued for the aborted frame.
- Latency from the IDLE cycle that sees `i_enable`=1 to `o_data_valid`: CS_SETUP + 2*CLK_DIV*DATA_WIDTH + 1 cycles.
- With `i_enable` held high, frames repeat every CS_SETUP + 2*CLK_DIV*DATA_WIDTH + 2 cycles. `o_cs_n` stays high for 2 cycles (DONE + IDLE) between frames.
- `o_data_valid` is never high on two consecutive cycles.
- `o_data` is stable at all times except the DONE cycle update.
- `i_miso` is sampled in the same system cycle in which `o_sclk` is driven high. The ADC must present bit n before the preceding falling edge.

## Configuration
- Macro: ADC_SPI_READER_SAMPLE_COUNT_EN.
- Defined:
  - Adds output port `o_sample_count` [15:0], reset 0.
  - It increments by 1 in each DONE cycle and wraps 0xFFFF -> 0x0000.
  - It updates in the same cycle as `o_data`.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
All scenarios use DATA_WIDTH=12, CLK_DIV=2, CS_SETUP=2.
- Single frame:
  - Stimulus: pulse `i_enable` for 1 cycle in IDLE; ADC model shifts 0xA5C MSB-first.
  - Response: `o_cs_n` low for exactly 50 cycles; exactly 12 SCLK rising edges; `o_data_valid` high for 1 cycle, 51 cycles after the enable sample; `o_data`=0xA5C; no further frame.
- Continuous:
  - Stimulus: `i_enable` held high; ADC returns 0x001, 0xFFF, 0x800.
  - Response: three `o_data_valid` pulses spaced 52 cycles apart with those values; `o_cs_n` high exactly 2 cycles between frames.
- Enable drop:
  - Stimulus: `i_enable` deasserted in cycle 10 of SHIFT.
  - Response: frame completes, one valid pulse, then IDLE with `o_busy`=0.
- Reset mid-SHIFT:
  - Stimulus: assert `i_reset` after 6 SCLK edges while `o_data`=0x123.
  - Response: outputs go immediately to reset values with no valid pulse. The next frame after reset is released returns the correct word.
- SCLK shape:
  - Check: every SCLK high and low phase is exactly 2 cycles; SCLK is 0 whenever `o_cs_n`=1.
- With ADC_SPI_READER_SAMPLE_COUNT_EN:
  - Stimulus: preload the counter to 0xFFFE via force, then run two frames.
  - Response: `o_sample_count` = 0xFFFF, then 0x0000.
